// File: rtl/sram_sh_data_pkg.sv
// Shared types and constants for the shared-data SRAM arbiter.
package sram_sh_data_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int BEN_WIDTH = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping modulo N.
module rr_arbiter
  import sram_sh_data_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] winner_o,
  output logic          any_gnt_o
);

  logic [N-1:0] rot;
  int           idx;

  always_comb begin
    any_gnt_o = 1'b0;
    winner_o  = '0;
    rot       = '0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx       = (int'(ptr_i) + k) % N;
      rot       = req_i >> idx;
      winner_o  = (!any_gnt_o && rot[0]) ? IW'(idx) : winner_o;
      any_gnt_o = any_gnt_o | rot[0];
    end
    gnt_o = any_gnt_o ? (N'(1'b1) << winner_o) : '0;
  end

endmodule

// File: rtl/sram_sh_data_arbiter.sv
// Shares one single-port SRAM among N_PORTS requesters with round-robin grants,
// fixed-latency responses and an optional post-reset zero-fill sweep.
module sram_sh_data_arbiter
  import sram_sh_data_pkg::*;
#(
  parameter int N_PORTS       = 4,
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 128,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter bit REG_RDATA     = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [N_PORTS-1:0]            req_i,
  output logic [N_PORTS-1:0]            gnt_o,
  input  logic [N_PORTS*ADDR_WIDTH-1:0] addr_i,
  input  logic [N_PORTS-1:0]            we_i,
  input  logic [N_PORTS*BEN_WIDTH-1:0]  be_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [N_PORTS-1:0]            r_valid_o,
  output logic [DATA_WIDTH-1:0]         r_rdata_o,
  output logic                          init_done_o,
  output logic                          CEN_o,
  output logic                          WEN_o,
  output logic [BEN_WIDTH-1:0]          BEN_o,
  output logic [ADDR_WIDTH-1:0]         A_o,
  output logic [DATA_WIDTH-1:0]         D_o,
  input  logic [DATA_WIDTH-1:0]         Q_i
);

  localparam int     IW        = idx_width(N_PORTS);
  localparam state_e RST_STATE = INIT_ON_RESET ? INIT : RUN;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BEN_WIDTH-1:0]  be;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic [N_PORTS-1:0] valid;
    logic               rd;
  } rsp_t;

  req_t                  port_req [N_PORTS];
  req_t                  sel_req;
  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_done_q;
  logic [IW-1:0]         rr_ptr_q;
  logic [IW-1:0]         rr_ptr_d;
  logic [IW-1:0]         winner;
  logic [N_PORTS-1:0]    arb_gnt;
  logic                  any_gnt;
  rsp_t                  rsp1_q;
  rsp_t                  rsp1_d;
  rsp_t                  rsp2_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      port_req[p].addr  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
      port_req[p].we    = we_i[p];
      port_req[p].be    = be_i[p*BEN_WIDTH +: BEN_WIDTH];
      port_req[p].wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_arbiter #(
    .N  (N_PORTS),
    .IW (IW)
  ) u_rr_arbiter (
    .req_i     (req_i),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .winner_o  (winner),
    .any_gnt_o (any_gnt)
  );

  always_comb begin
    sel_req = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      sel_req = (IW'(p) == winner) ? port_req[p] : sel_req;
    end
  end

  // Memory port is driven straight from the arbiter; reset forces it idle.
  always_comb begin
    gnt_o    = '0;
    CEN_o    = 1'b1;
    WEN_o    = 1'b1;
    BEN_o    = '1;
    A_o      = '0;
    D_o      = '0;
    rsp1_d   = '0;
    rr_ptr_d = rr_ptr_q;
    if (rst_i) begin
      rr_ptr_d = '0;
    end else if (state_q == INIT) begin
      CEN_o = 1'b0;
      WEN_o = 1'b0;
      BEN_o = '0;
      A_o   = cnt_q;
    end else if (any_gnt) begin
      gnt_o        = arb_gnt;
      CEN_o        = 1'b0;
      WEN_o        = ~sel_req.we;
      BEN_o        = ~sel_req.be;
      A_o          = sel_req.addr;
      D_o          = sel_req.wdata;
      rsp1_d.valid = arb_gnt;
      rsp1_d.rd    = ~sel_req.we;
      rr_ptr_d     = IW'((int'(winner) + 1) % N_PORTS);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end else begin
            state_q     <= INIT;
            init_done_q <= 1'b0;
          end
        end
        RUN: begin
          state_q     <= RUN;
          init_done_q <= 1'b1;
        end
        default: begin
          state_q     <= RST_STATE;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      rsp1_q   <= '0;
      rsp2_q   <= '0;
      rdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rsp1_q   <= rsp1_d;
      rsp2_q   <= rsp1_q;
      rdata_q  <= rdata_d;
    end
  end

  // Q_i is only trusted the cycle after a read; otherwise the last read data is held.
  always_comb begin
    rdata_d   = (rsp1_q.rd && (|rsp1_q.valid)) ? Q_i : rdata_q;
    r_valid_o = REG_RDATA ? rsp2_q.valid : rsp1_q.valid;
    r_rdata_o = REG_RDATA ? rdata_q : rdata_d;
  end

  assign init_done_o = init_done_q;

endmodule
